// File: rtl/mdu_pkg.sv
// Shared types and defaults for the multiply/divide unit.
// Op codes, latency defaults and the sequencer state encoding.
package mdu_pkg;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MFHI  = 4'd5,
        OP_MFLO  = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8,
        OP_MADD  = 4'd9,
        OP_MADDU = 4'd10,
        OP_MSUB  = 4'd11,
        OP_MSUBU = 4'd12
    } mdu_op_e;

    localparam int MUL_LAT_DEF = 5;
    localparam int DIV_LAT_DEF = 10;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mdu_state_e;

endpackage

// File: rtl/mdu_unit.sv
// Multiply/divide unit owning HI/LO with start/busy latency model.
// Optional MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU accumulate ops.
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid,
    input  logic [3:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        start,
    output logic        busy,
    output logic [31:0] rdata
);

    localparam int LAT_MAX = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW      = $clog2(LAT_MAX + 1);

    mdu_op_e    op_e;
    mdu_state_e state_q;
    mdu_state_e state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    logic        is_mul;
    logic        is_div;
    logic        commit;
    logic        mt_hi;
    logic        mt_lo;

    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [31:0] pend_hi;
    logic [31:0] pend_lo;
    logic        pend_wr;

    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        div_ovf;
    logic [31:0] dv_s;
    logic [31:0] dv_u;
    logic signed [31:0] sq;
    logic signed [31:0] sr;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [63:0] res;

    assign op_e = mdu_op_e'(op);

    // Classify the presented op into multiply- and divide-class.
    always_comb begin
        is_mul = 1'b0;
        is_div = 1'b0;
        unique case (1'b1)
            (op_e == OP_MULT),
            (op_e == OP_MULTU): is_mul = 1'b1;
            (op_e == OP_DIV),
            (op_e == OP_DIVU):  is_div = 1'b1;
`ifdef MDU_MADD_EN
            (op_e == OP_MADD),
            (op_e == OP_MADDU),
            (op_e == OP_MSUB),
            (op_e == OP_MSUBU): is_mul = 1'b1;
`else
            (op_e == OP_MADD),
            (op_e == OP_MADDU),
            (op_e == OP_MSUB),
            (op_e == OP_MSUBU): ;
`endif
            default: ;
        endcase
    end

    assign busy  = (state_q == RUN);
    assign start = valid & (is_mul | is_div) & ~busy;
    assign mt_hi = valid & ~busy & (op_e == OP_MTHI);
    assign mt_lo = valid & ~busy & (op_e == OP_MTLO);
    assign rdata = (op_e == OP_MFHI) ? hi_q : lo_q;

    // Arithmetic on the live operands; only captured when start is high.
    // A zero divisor or INT_MIN/-1 is steered to a divide-by-one so the
    // divider never sees an undefined case; INT_MIN/1 is the wanted answer.
    assign sa      = {{32{rs_data[31]}}, rs_data};
    assign sb      = {{32{rt_data[31]}}, rt_data};
    assign prod_s  = sa * sb;
    assign prod_u  = {32'd0, rs_data} * {32'd0, rt_data};
    assign div_ovf = (rs_data == 32'h8000_0000) &&
                     (rt_data == 32'hFFFF_FFFF);
    assign dv_s    = ((rt_data == 32'd0) || div_ovf) ? 32'd1 : rt_data;
    assign dv_u    = (rt_data == 32'd0) ? 32'd1 : rt_data;
    assign sq      = $signed(rs_data) / $signed(dv_s);
    assign sr      = $signed(rs_data) % $signed(dv_s);
    assign uq      = rs_data / dv_u;
    assign ur      = rs_data % dv_u;

    // Select the 64-bit {hi,lo} result for the accepted op.
    always_comb begin
        res = '0;
        unique case (1'b1)
            (op_e == OP_MULT):  res = prod_s;
            (op_e == OP_MULTU): res = prod_u;
            (op_e == OP_DIV):   res = {sr, sq};
            (op_e == OP_DIVU):  res = {ur, uq};
`ifdef MDU_MADD_EN
            (op_e == OP_MADD):  res = {hi_q, lo_q} + prod_s;
            (op_e == OP_MADDU): res = {hi_q, lo_q} + prod_u;
            (op_e == OP_MSUB):  res = {hi_q, lo_q} - prod_s;
            (op_e == OP_MSUBU): res = {hi_q, lo_q} - prod_u;
`endif
            default: ;
        endcase
    end

    // Sequencer next state: load latency on accept, count down in RUN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = is_div ? CW'(DIV_LAT) : CW'(MUL_LAT);
                end
            end
            RUN: begin
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: ;
        endcase
    end

    // Sequencer state and latency counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Pending result capture, HI/LO commit and direct mt* writes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q    <= '0;
            lo_q    <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_wr <= 1'b0;
        end else begin
            if (start) begin
                pend_hi <= res[63:32];
                pend_lo <= res[31:0];
                pend_wr <= ~(is_div && (rt_data == 32'd0));
            end
            if (commit && pend_wr) begin
                hi_q <= pend_hi;
                lo_q <= pend_lo;
            end else begin
                if (mt_hi) hi_q <= rs_data;
                if (mt_lo) lo_q <= rs_data;
            end
        end
    end

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit against a 64-bit arithmetic model.
// Define MDU_MADD_EN on both RTL and bench to exercise accumulate ops.
module tb_mdu_unit;
    import mdu_pkg::*;

    localparam int ML = MUL_LAT_DEF;
    localparam int DL = DIV_LAT_DEF;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid;
    logic [3:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        start;
    logic        busy;
    logic [31:0] rdata;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mdu_unit #(.MUL_LAT(ML), .DIV_LAT(DL)) dut (
        .clk(clk), .reset(reset), .valid(valid), .op(op),
        .rs_data(rs_data), .rt_data(rt_data),
        .start(start), .busy(busy), .rdata(rdata)
    );

    always #5 clk = ~clk;

    function automatic int lat_of(mdu_op_e o);
        case (o)
            OP_MULT, OP_MULTU: return ML;
            OP_DIV, OP_DIVU:   return DL;
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: return ML;
`endif
            default: return 0;
        endcase
    endfunction

    function automatic void model_apply(mdu_op_e o, logic [31:0] a,
                                        logic [31:0] b);
        longint sp;
        longint unsigned up;
        longint x;
        longint y;
        sp = longint'($signed(a)) * longint'($signed(b));
        up = longint'(a) * longint'(b);
        x  = longint'($signed(a));
        y  = longint'($signed(b));
        case (o)
            OP_MULT:  {m_hi, m_lo} = sp;
            OP_MULTU: {m_hi, m_lo} = up;
            OP_DIV: if (b != 0) begin
                m_lo = 32'(x / y);
                m_hi = 32'(x % y);
            end
            OP_DIVU: if (b != 0) begin
                m_lo = a / b;
                m_hi = a % b;
            end
            OP_MTHI: m_hi = a;
            OP_MTLO: m_lo = a;
`ifdef MDU_MADD_EN
            OP_MADD:  {m_hi, m_lo} = {m_hi, m_lo} + 64'(sp);
            OP_MADDU: {m_hi, m_lo} = {m_hi, m_lo} + up;
            OP_MSUB:  {m_hi, m_lo} = {m_hi, m_lo} - 64'(sp);
            OP_MSUBU: {m_hi, m_lo} = {m_hi, m_lo} - up;
`endif
            default: ;
        endcase
    endfunction

    task automatic idle_inputs();
        valid   = 1'b0;
        op      = OP_NONE;
        rs_data = $urandom;
        rt_data = $urandom;
    endtask

    // Present one op for a cycle, then count busy cycles (bounded).
    // Returns at #1 into the first cycle with busy low.
    task automatic do_op(input mdu_op_e o, input logic [31:0] a,
                         input logic [31:0] b, output bit st,
                         output int nb);
        @(posedge clk); #1;
        valid   = 1'b1;
        op      = o;
        rs_data = a;
        rt_data = b;
        #2 st = start;
        @(posedge clk); #1;
        idle_inputs();
        nb = 0;
        while (busy === 1'b1 && nb < 200) begin
            nb++;
            @(posedge clk); #1;
        end
    endtask

    task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
        op = OP_MFHI;
        #1 h = rdata;
        op = OP_MFLO;
        #1 l = rdata;
        op = OP_NONE;
    endtask

    task automatic test_reset();
        logic [31:0] h, l;
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        m_hi = 0;
        m_lo = 0;
        @(posedge clk); #1;
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy got %b want 0", busy);
        end
        n_chk++;
        if (start !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_start got %b want 0", start);
        end
        read_hilo(h, l);
        n_chk++;
        if (h !== 32'd0 || l !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_hilo got %h:%h want 0:0", h, l);
        end
    endtask

    task automatic test_mult();
        bit st;
        int nb;
        logic [31:0] h, l;
        do_op(OP_MULT, 32'hFFFF_FFFF, 32'd2, st, nb);
        model_apply(OP_MULT, 32'hFFFF_FFFF, 32'd2);
        read_hilo(h, l);
        n_chk++;
        if (st !== 1'b1 || nb != ML) begin
            n_fail++;
            $display("FAIL mult_timing start=%b busy=%0d want 1/%0d",
                     st, nb, ML);
        end
        n_chk++;
        if (h !== 32'hFFFF_FFFF || l !== 32'hFFFF_FFFE) begin
            n_fail++;
            $display("FAIL mult_result got %h:%h want ffffffff:fffffffe",
                     h, l);
        end
        do_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2, st, nb);
        model_apply(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
        read_hilo(h, l);
        n_chk++;
        if (h !== 32'h1 || l !== 32'hFFFF_FFFE || nb != ML) begin
            n_fail++;
            $display("FAIL multu_result got %h:%h busy=%0d want 1:fffffffe",
                     h, l, nb);
        end
    endtask

    task automatic test_div();
        bit st;
        int nb;
        logic [31:0] h, l;
        do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, st, nb);
        model_apply(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        read_hilo(h, l);
        n_chk++;
        if (st !== 1'b1 || nb != DL) begin
            n_fail++;
            $display("FAIL div_timing start=%b busy=%0d want 1/%0d",
                     st, nb, DL);
        end
        n_chk++;
        if (h !== 32'hFFFF_FFFF || l !== 32'hFFFF_FFFD) begin
            n_fail++;
            $display("FAIL div_result got %h:%h want ffffffff:fffffffd",
                     h, l);
        end
        do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, st, nb);
        model_apply(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        read_hilo(h, l);
        n_chk++;
        if (h !== 32'd0 || l !== 32'h8000_0000) begin
            n_fail++;
            $display("FAIL div_ovf got %h:%h want 0:80000000", h, l);
        end
    endtask

    task automatic test_div_zero();
        bit st;
        int nb;
        logic [31:0] h, l;
        do_op(OP_MTHI, 32'h11, 32'd0, st, nb);
        model_apply(OP_MTHI, 32'h11, 32'd0);
        read_hilo(h, l);
        n_chk++;
        if (st !== 1'b0 || nb != 0 || h !== 32'h11) begin
            n_fail++;
            $display("FAIL mthi start=%b busy=%0d hi=%h want 0/0/11",
                     st, nb, h);
        end
        do_op(OP_MTLO, 32'h22, 32'd0, st, nb);
        model_apply(OP_MTLO, 32'h22, 32'd0);
        do_op(OP_DIVU, 32'd5, 32'd0, st, nb);
        model_apply(OP_DIVU, 32'd5, 32'd0);
        read_hilo(h, l);
        n_chk++;
        if (st !== 1'b1 || nb != DL) begin
            n_fail++;
            $display("FAIL divz_timing start=%b busy=%0d want 1/%0d",
                     st, nb, DL);
        end
        n_chk++;
        if (h !== 32'h11 || l !== 32'h22) begin
            n_fail++;
            $display("FAIL divz_hilo got %h:%h want 11:22", h, l);
        end
    endtask

    task automatic test_busy_ignore();
        bit st;
        int nb;
        logic [31:0] h, l;
        do_op(OP_MTLO, 32'h33, 32'd0, st, nb);
        model_apply(OP_MTLO, 32'h33, 32'd0);
        @(posedge clk); #1;
        valid   = 1'b1;
        op      = OP_MULT;
        rs_data = 32'd6;
        rt_data = 32'd7;
        @(posedge clk); #1;
        op      = OP_MTLO;
        rs_data = 32'hDEAD;
        #2;
        n_chk++;
        if (busy !== 1'b1 || start !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_mt busy=%b start=%b want 1/0", busy, start);
        end
        @(posedge clk); #1;
        op      = OP_MULT;
        rs_data = 32'd9;
        rt_data = 32'd9;
        #2;
        n_chk++;
        if (start !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_start got %b want 0", start);
        end
        @(posedge clk); #1;
        idle_inputs();
        nb = 2;
        while (busy === 1'b1 && nb < 200) begin
            nb++;
            @(posedge clk); #1;
        end
        model_apply(OP_MULT, 32'd6, 32'd7);
        read_hilo(h, l);
        n_chk++;
        if (nb != ML || h !== m_hi || l !== m_lo) begin
            n_fail++;
            $display("FAIL busy_ignore got %h:%h busy=%0d want %h:%h/%0d",
                     h, l, nb, m_hi, m_lo, ML);
        end
    endtask

    task automatic test_reset_mid_run();
        bit st;
        int nb;
        logic [31:0] h, l;
        do_op(OP_MTHI, 32'h55, 32'd0, st, nb);
        do_op(OP_MTLO, 32'h66, 32'd0, st, nb);
        @(posedge clk); #1;
        valid   = 1'b1;
        op      = OP_MULT;
        rs_data = 32'd3;
        rt_data = 32'd3;
        @(posedge clk); #1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_busy got %b want 0", busy);
        end
        read_hilo(h, l);
        n_chk++;
        if (h !== 32'd0 || l !== 32'd0) begin
            n_fail++;
            $display("FAIL midrst_hilo got %h:%h want 0:0", h, l);
        end
        #1 reset = 1'b0;
        m_hi = 0;
        m_lo = 0;
        repeat (ML + 2) @(posedge clk);
        #1 read_hilo(h, l);
        n_chk++;
        if (busy !== 1'b0 || h !== 32'd0 || l !== 32'd0) begin
            n_fail++;
            $display("FAIL midrst_after busy=%b got %h:%h want 0:0",
                     busy, h, l);
        end
    endtask

    task automatic test_back_to_back();
        bit st;
        int nb;
        logic [31:0] a, b, c, d, h, l;
        a = $urandom;
        b = $urandom;
        c = $urandom;
        d = $urandom_range(1, 1000);
        do_op(OP_MULTU, a, b, st, nb);
        model_apply(OP_MULTU, a, b);
        valid   = 1'b1;
        op      = OP_DIVU;
        rs_data = c;
        rt_data = d;
        #1;
        n_chk++;
        if (start !== 1'b1 || rdata !== m_lo) begin
            n_fail++;
            $display("FAIL b2b_accept start=%b rdata=%h want 1/%h",
                     start, rdata, m_lo);
        end
        @(posedge clk); #1;
        idle_inputs();
        nb = 0;
        while (busy === 1'b1 && nb < 200) begin
            nb++;
            @(posedge clk); #1;
        end
        model_apply(OP_DIVU, c, d);
        read_hilo(h, l);
        n_chk++;
        if (nb != DL || h !== m_hi || l !== m_lo) begin
            n_fail++;
            $display("FAIL b2b_div got %h:%h busy=%0d want %h:%h/%0d",
                     h, l, nb, m_hi, m_lo, DL);
        end
    endtask

    task automatic test_madd();
        bit st;
        int nb;
        logic [31:0] h, l;
        do_op(OP_MTHI, 32'd0, 32'd0, st, nb);
        do_op(OP_MTLO, 32'd5, 32'd0, st, nb);
        m_hi = 32'd0;
        m_lo = 32'd5;
        do_op(OP_MADD, 32'd3, 32'd4, st, nb);
        read_hilo(h, l);
`ifdef MDU_MADD_EN
        n_chk++;
        if (st !== 1'b1 || nb != ML || h !== 32'd0 || l !== 32'd17) begin
            n_fail++;
            $display("FAIL madd start=%b busy=%0d got %h:%h want 1/%0d 0:11",
                     st, nb, h, l, ML);
        end
        model_apply(OP_MADD, 32'd3, 32'd4);
        do_op(OP_MSUB, 32'd2, 32'd10, st, nb);
        model_apply(OP_MSUB, 32'd2, 32'd10);
        read_hilo(h, l);
        n_chk++;
        if (h !== 32'hFFFF_FFFF || l !== 32'hFFFF_FFFD) begin
            n_fail++;
            $display("FAIL msub got %h:%h want ffffffff:fffffffd", h, l);
        end
`else
        n_chk++;
        if (st !== 1'b0 || nb != 0 || h !== 32'd0 || l !== 32'd5) begin
            n_fail++;
            $display("FAIL madd_off start=%b busy=%0d got %h:%h want 0/0 0:5",
                     st, nb, h, l);
        end
`endif
    endtask

    task automatic test_random();
        mdu_op_e ops [6] = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
                             OP_MTHI, OP_MTLO};
        mdu_op_e o;
        bit st;
        int nb;
        int lat;
        logic [31:0] a, b, h, l;
        for (int i = 0; i < 40; i++) begin
            o = ops[$urandom_range(0, 5)];
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = $urandom_range(1, 15);
                default: ;
            endcase
            lat = lat_of(o);
            do_op(o, a, b, st, nb);
            model_apply(o, a, b);
            read_hilo(h, l);
            n_chk++;
            if (st !== (lat > 0) || nb != lat) begin
                n_fail++;
                $display("FAIL rand_timing i=%0d op=%0d start=%b busy=%0d want %0d",
                         i, o, st, nb, lat);
            end
            n_chk++;
            if (h !== m_hi || l !== m_lo) begin
                n_fail++;
                $display("FAIL rand_result i=%0d op=%0d a=%h b=%h got %h:%h want %h:%h",
                         i, o, a, b, h, l, m_hi, m_lo);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        idle_inputs();
        m_hi = 0;
        m_lo = 0;
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_busy_ignore();
        test_reset_mid_run();
        test_back_to_back();
        test_madd();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
